// File: rtl/dcache_axi_write_master.sv
// dcache_axi_write_master: drains one dirty cache line from the write buffer as a single AXI4 INCR write burst.
// Latency: request to mem_bvalid_o pulse is 12 cycles minimum with a zero-wait slave (11 with AXI_AW_W_OVERLAP_EN).
// Backpressure: awvalid_o/wvalid_o are held until their handshake; mem_wen_i is only sampled in IDLE.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   mem_wen_i/awaddr/wdata   write-buffer request (level), line address, full line data
//   mem_bvalid_o, busy_o     one-cycle completion pulse; transaction in flight
//   aw*/w*/b*                AXI4 write address, write data and write response channels
//
// Optional feature macro: AXI_AW_W_OVERLAP_EN
//   defined   -> AW and W are issued together and their handshakes are tracked independently
//   undefined -> strict AW-then-W ordering
module dcache_axi_write_master #(
  parameter int         LINE_WORDS = 8,
  parameter int         ADDR_W     = 32,
  parameter int         DATA_W     = 32,
  parameter logic [3:0] AXI_ID     = 4'b0001
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_wen_i,
  input  logic [ADDR_W-1:0]            mem_awaddr_i,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_wdata_i,
  output logic                         mem_bvalid_o,
  output logic                         busy_o,
  output logic [3:0]                   awid_o,
  output logic [ADDR_W-1:0]            awaddr_o,
  output logic [7:0]                   awlen_o,
  output logic [2:0]                   awsize_o,
  output logic [1:0]                   awburst_o,
  output logic                         awvalid_o,
  input  logic                         awready_i,
  output logic [DATA_W-1:0]            wdata_o,
  output logic [3:0]                   wstrb_o,
  output logic                         wlast_o,
  output logic                         wvalid_o,
  input  logic                         wready_i,
  input  logic [1:0]                   bresp_i,
  input  logic                         bvalid_i,
  output logic                         bready_o
);

  localparam int                BEAT_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    RESP,
    DONE
  } state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [BEAT_W-1:0]            r_beat;
  logic [ADDR_W-1:0]            r_awaddr;
  logic [LINE_WORDS*DATA_W-1:0] r_line;

  logic w_accept;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_last_hs;

  // The write response code carries no information this block acts on.
  logic w_unused;
  assign w_unused = ^bresp_i;

  assign w_accept  = (r_state == IDLE) && mem_wen_i;
  assign w_aw_hs   = awvalid_o && awready_i;
  assign w_w_hs    = wvalid_o && wready_i;
  assign w_last_hs = w_w_hs && (r_beat == LAST_BEAT);

`ifdef AXI_AW_W_OVERLAP_EN
  // Each channel retires independently inside DATA; a flag remembers the
  // handshake so the channel's valid drops and stays low until RESP.
  logic r_aw_done;
  logic r_w_done;

  assign awvalid_o = (r_state == DATA) && !r_aw_done;
  assign wvalid_o  = (r_state == DATA) && !r_w_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else if (w_accept) begin
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      if (w_aw_hs)   r_aw_done <= 1'b1;
      if (w_last_hs) r_w_done  <= 1'b1;
    end
  end
`else
  assign awvalid_o = (r_state == ADDR);
  assign wvalid_o  = (r_state == DATA);
`endif

  // Constant AXI attributes: full-width INCR beats, all bytes enabled.
  assign awid_o    = AXI_ID;
  assign awlen_o   = 8'(LINE_WORDS - 1);
  assign awsize_o  = 3'b010;
  assign awburst_o = 2'b01;
  assign wstrb_o   = 4'hF;

  assign awaddr_o     = r_awaddr;
  assign wdata_o      = r_line[r_beat*DATA_W +: DATA_W];
  assign wlast_o      = (r_beat == LAST_BEAT);
  assign bready_o     = (r_state == RESP);
  assign mem_bvalid_o = (r_state == DONE);
  assign busy_o       = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (mem_wen_i) begin
`ifdef AXI_AW_W_OVERLAP_EN
          w_next = DATA;
`else
          w_next = ADDR;
`endif
        end
      end
      ADDR: begin
        if (w_aw_hs) w_next = DATA;
      end
      DATA: begin
`ifdef AXI_AW_W_OVERLAP_EN
        // Either channel may finish first; a same-cycle handshake counts too.
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_last_hs)) w_next = RESP;
`else
        if (w_last_hs) w_next = RESP;
`endif
      end
      RESP: begin
        if (bvalid_i) w_next = DONE;
      end
      DONE: begin
        // mem_wen_i is deliberately ignored here: the buffer is still
        // reacting to this cycle's completion pulse.
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // The line is captured at acceptance so the buffer can rewrite its entry
  // while the burst is still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_awaddr <= '0;
      r_line   <= '0;
      r_beat   <= '0;
    end else if (w_accept) begin
      r_awaddr <= mem_awaddr_i;
      r_line   <= mem_wdata_i;
      r_beat   <= '0;
    end else if (w_w_hs) begin
      r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + 1'b1;
    end
  end

endmodule

// File: tb/tb_dcache_axi_write_master.sv
module tb_dcache_axi_write_master;

  localparam int LW = 8;
`ifdef AXI_AW_W_OVERLAP_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 12;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_wen_i;
  logic [31:0]  mem_awaddr_i;
  logic [255:0] mem_wdata_i;
  logic         mem_bvalid_o, busy_o;
  logic [3:0]   awid_o;
  logic [31:0]  awaddr_o;
  logic [7:0]   awlen_o;
  logic [2:0]   awsize_o;
  logic [1:0]   awburst_o;
  logic         awvalid_o, awready_i;
  logic [31:0]  wdata_o;
  logic [3:0]   wstrb_o;
  logic         wlast_o, wvalid_o, wready_i;
  logic [1:0]   bresp_i;
  logic         bvalid_i, bready_o;

  dcache_axi_write_master dut (
    .clk(clk), .rst(rst),
    .mem_wen_i(mem_wen_i), .mem_awaddr_i(mem_awaddr_i), .mem_wdata_i(mem_wdata_i),
    .mem_bvalid_o(mem_bvalid_o), .busy_o(busy_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: each accepted request becomes one expected burst that
  // carries exactly the address and line presented when it was accepted.
  typedef struct {
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- slave model ----------------
  int aw_wait = 0, b_wait = 0, w_mode = 0;
  int aw_cnt = 0, b_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (awvalid_o) begin
      awready_i = (aw_cnt >= aw_wait);
      aw_cnt++;
    end else begin
      awready_i = 1'b0;
      aw_cnt = 0;
    end
    case (w_mode)
      0:       wready_i = 1'b1;
      1:       wready_i = ~wready_i;
      default: wready_i = 1'($urandom_range(0, 1));
    endcase
    if (bready_o) begin
      bvalid_i = (b_cnt >= b_wait);
      bresp_i  = 2'($urandom_range(0, 3));
      b_cnt++;
    end else begin
      bvalid_i = 1'b0;
      b_cnt = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          m_beats = 0;
  bit          m_aw = 0, m_b = 0;
  int          n_done = 0, done_cyc = 0;
  logic        prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0, prev_mb = 0, prev_wlast = 0;
  logic [31:0] prev_awaddr = 0, prev_wdata = 0;

  always @(negedge clk) begin
    if (!rst) begin
      m_beats = 0; m_aw = 0; m_b = 0;
      prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0; prev_mb = 0;
    end else begin
      if (prev_awv && !prev_awr) begin
        chk("aw_valid_held", 64'(awvalid_o), 64'd1);
        chk("aw_addr_stable", 64'(awaddr_o), 64'(prev_awaddr));
      end
      if (prev_wv && !prev_wr) begin
        chk("w_valid_held", 64'(wvalid_o), 64'd1);
        chk("w_data_stable", 64'(wdata_o), 64'(prev_wdata));
        chk("w_last_stable", 64'(wlast_o), 64'(prev_wlast));
      end
`ifndef AXI_AW_W_OVERLAP_EN
      if (wvalid_o) chk("w_before_aw", 64'(m_aw), 64'd1);
`endif
      if (bready_o) chk("bready_early", 64'({m_aw, m_beats == LW}), 64'd3);
      if (awvalid_o && awready_i) begin
        if (exp_q.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
        else begin
          chk("awaddr", 64'(awaddr_o), 64'(exp_q[0].addr));
          chk("aw_once", 64'(m_aw), 64'd0);
          chk("aw_attr", 64'({awid_o, awlen_o, awsize_o, awburst_o}), 64'({4'b0001, 8'd7, 3'b010, 2'b01}));
        end
        m_aw = 1;
      end
      if (wvalid_o && wready_i) begin
        if (exp_q.size() == 0 || m_beats >= LW) chk("w_unexpected", 64'(m_beats), 64'd0);
        else begin
          chk("wdata", 64'(wdata_o), 64'(exp_q[0].line[m_beats*32 +: 32]));
          chk("wlast", 64'(wlast_o), 64'(m_beats == LW - 1));
          chk("wstrb", 64'(wstrb_o), 64'hF);
        end
        m_beats++;
      end
      if (bvalid_i && bready_o) m_b = 1;
      if (mem_bvalid_o) begin
        chk("bvalid_pulse_width", 64'(prev_mb), 64'd0);
        chk("burst_complete", 64'({m_aw, m_beats == LW, m_b}), 64'd7);
        if (exp_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
        else void'(exp_q.pop_front());
        n_done++;
        done_cyc = cyc;
        m_beats = 0; m_aw = 0; m_b = 0;
      end
      prev_awv = awvalid_o; prev_awr = awready_i; prev_awaddr = awaddr_o;
      prev_wv = wvalid_o; prev_wr = wready_i; prev_wdata = wdata_o; prev_wlast = wlast_o;
      prev_mb = mem_bvalid_o;
    end
  end

  // ---------------- stimulus ----------------
  int req_cyc = 0;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < LW; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[4:0] = 5'b0;
    return a;
  endfunction

  // Called at posedge+1 while the DUT is idle; wen is held for one cycle,
  // then address/data are scrambled to prove the line was latched.
  task automatic issue(input logic [31:0] addr, input logic [255:0] line);
    exp_t e;
    e.addr = addr;
    e.line = line;
    exp_q.push_back(e);
    mem_wen_i = 1'b1; mem_awaddr_i = addr; mem_wdata_i = line;
    req_cyc = cyc;
    @(posedge clk); #1;
    mem_wen_i = 1'b0; mem_awaddr_i = $urandom; mem_wdata_i = rand_line();
  endtask

  task automatic wait_done(input int target, input int budget);
    int t = 0;
    while (n_done < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("done_timeout", 64'(n_done >= target), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, n_done=%0d", n_done);
    $fatal(1);
  end

  initial begin
    logic [255:0] line_a, line_b;
    logic [31:0]  addr_b;
    int t, saved;
    rst = 1'b1; mem_wen_i = 1'b0; mem_awaddr_i = '0; mem_wdata_i = '0;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 64'({busy_o, awvalid_o, wvalid_o, bready_o, mem_bvalid_o}), 64'd0);
    chk("rst_awaddr", 64'(awaddr_o), 64'd0);
    chk("rst_attr", 64'({awid_o, awlen_o, awsize_o, awburst_o, wstrb_o}),
        64'({4'b0001, 8'd7, 3'b010, 2'b01, 4'hF}));
    rst = 1'b1;
    @(posedge clk); #1;

    // Zero-wait burst with ascending word pattern; also checks latency.
    for (int k = 0; k < LW; k++) line_a[k*32 +: 32] = 32'h11111111 * (k + 1);
    issue(32'h1FC0_0020, line_a);
    wait_done(1, 100);
    chk("latency", 64'(done_cyc - req_cyc + 1), 64'(LAT));

    // AW stalled five cycles.
    aw_wait = 5;
    issue(rand_addr(), rand_line());
    wait_done(2, 100);
    aw_wait = 0;

    // W stalled every other cycle.
    w_mode = 1;
    issue(32'h0000_1000, line_a);
    wait_done(3, 100);
    w_mode = 0;

    // Buffer rewrites its entry mid-burst and keeps wen high.
    line_a = rand_line();
    for (int k = 0; k < LW; k++) line_b[k*32 +: 32] = 32'hDEAD_0000 + 32'(k);
    addr_b = 32'h2000_0040;
    begin
      exp_t e;
      e.addr = 32'h3000_0080;
      e.line = line_a;
      exp_q.push_back(e);
    end
    mem_wen_i = 1'b1; mem_awaddr_i = 32'h3000_0080; mem_wdata_i = line_a;
    t = 0;
    while (!wvalid_o && t < 20) begin @(posedge clk); #1; t++; end
    chk("reach_data_phase", 64'(wvalid_o), 64'd1);
    begin
      exp_t e;
      e.addr = addr_b;
      e.line = line_b;
      exp_q.push_back(e);
    end
    mem_awaddr_i = addr_b; mem_wdata_i = line_b;
    wait_done(4, 100);
    @(posedge clk); #1;
    chk("restart_after_done", 64'({busy_o, awvalid_o}), 64'd3);
    mem_wen_i = 1'b0;
    wait_done(5, 100);

    // Reset in the middle of the data phase.
    issue(rand_addr(), rand_line());
    t = 0;
    while (m_beats < 4 && t < 50) begin @(posedge clk); #1; t++; end
    chk("reach_beat4", 64'(m_beats), 64'd4);
    saved = n_done;
    rst = 1'b0;
    #1;
    chk("midrst_outputs", 64'({busy_o, awvalid_o, wvalid_o, bready_o, mem_bvalid_o}), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'({mem_bvalid_o, n_done != saved}), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    issue(rand_addr(), rand_line());
    wait_done(saved + 1, 100);

    // AW accepted only well after the last W beat.
    aw_wait = 12;
    issue(rand_addr(), rand_line());
    wait_done(saved + 2, 100);
    aw_wait = 0;

    // Randomised slave timing.
    for (int i = 0; i < 25; i++) begin
      aw_wait = $urandom_range(0, 3);
      b_wait  = $urandom_range(0, 3);
      w_mode  = $urandom_range(0, 2);
      issue(rand_addr(), rand_line());
      wait_done(saved + 3 + i, 300);
    end
    w_mode = 0; aw_wait = 0; b_wait = 0;
    repeat (3) @(posedge clk); #1;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
